// File: rtl/uart_rx_word_deserializer.sv
// -----------------------------------------------------------------------------
// uart_rx_word_deserializer
//
// Collects sampled serial bits, one per bit_en strobe, into a word whose length
// and bit order are chosen at run time. The finished word is presented on a
// valid/ready output register. If a word completes while the output still holds
// an unconsumed word, the new word is dropped and overrun pulses. The block sits
// between the RX sampler/FSM and the RX FIFO.
//
// Optional feature: define UART_DESER_PARITY_EN to add a parity bit after the
// data bits. This adds the cfg_par_en and cfg_par_odd inputs and the
// out_par_err output.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   clear          synchronous abort: drops the partial word and returns to IDLE
//   bit_en         one-cycle strobe: bit_in is a valid data or parity bit
//   bit_in         sampled serial bit
//   cfg_len        data bits per word; 0 or a value > DATA_WIDTH means DATA_WIDTH
//   cfg_msb_first  1: the first bit received is the MSB; 0: the first bit is the LSB
//   cfg_par_en     (parity build only) a parity bit follows the data bits
//   cfg_par_odd    (parity build only) 1: odd parity, 0: even parity
//   out_ready      consumer accepts out_data when out_valid & out_ready
//   out_valid      out_data holds an unconsumed word
//   out_data       completed word, right-justified, unused upper bits 0
//   out_par_err    (parity build only) parity error flag that travels with out_data
//   overrun        one-cycle pulse: a completed word was dropped
//   busy           a word is in progress (state != IDLE)
//   bit_cnt        data bits captured so far in the current word
// -----------------------------------------------------------------------------
module uart_rx_word_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  bit_en,
    input  logic                  bit_in,
    input  logic [LEN_W-1:0]      cfg_len,
    input  logic                  cfg_msb_first,
`ifdef UART_DESER_PARITY_EN
    input  logic                  cfg_par_en,
    input  logic                  cfg_par_odd,
    output logic                  out_par_err,
`endif
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  overrun,
    output logic                  busy,
    output logic [LEN_W-1:0]      bit_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
`ifdef UART_DESER_PARITY_EN
        S_PAR   = 2'd2,
`endif
        S_SHIFT = 2'd1
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [LEN_W-1:0]      r_cnt;
    logic [LEN_W-1:0]      r_len;
    logic                  r_msb;
    logic                  r_cmp_valid;   // a word finished on the previous edge
    logic [DATA_WIDTH-1:0] r_cmp_data;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_overrun;
`ifdef UART_DESER_PARITY_EN
    logic                  r_par_en;
    logic                  r_par_odd;
    logic                  r_cmp_perr;
    logic                  r_out_perr;
    logic                  w_par_en;
`endif

    logic [LEN_W-1:0]      w_cfg_len;
    logic [LEN_W-1:0]      w_len;
    logic [LEN_W-1:0]      w_cnt;
    logic [LEN_W-1:0]      w_idx;
    logic                  w_msb;
    logic [DATA_WIDTH-1:0] w_base;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_last;

    // In IDLE, the strobe that starts a word uses the live cfg inputs and an
    // all-zero shift register. After that, the values latched at frame start
    // are used.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        w_cfg_len = cfg_len;
        if (cfg_len == '0 || cfg_len > LEN_W'(DATA_WIDTH))
            w_cfg_len = LEN_W'(DATA_WIDTH);
        w_len  = (r_state == S_IDLE) ? w_cfg_len     : r_len;
        w_msb  = (r_state == S_IDLE) ? cfg_msb_first : r_msb;
        w_base = (r_state == S_IDLE) ? '0            : r_shift;
        w_cnt  = (r_state == S_IDLE) ? '0            : r_cnt;
        // The k-th bit goes to index k (LSB first) or len-1-k (MSB first).
        w_idx  = w_msb ? (w_len - LEN_W'(1) - w_cnt) : w_cnt;
        w_word = bit_in ? (w_base | (DATA_WIDTH'(1) << w_idx)) : w_base;
        w_last = (w_cnt + LEN_W'(1)) == w_len;
`ifdef UART_DESER_PARITY_EN
        w_par_en = (r_state == S_IDLE) ? cfg_par_en : r_par_en;
`endif
    end

    // Capture FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_len       <= LEN_W'(DATA_WIDTH);
            r_msb       <= 1'b0;
            r_cmp_valid <= 1'b0;
            r_cmp_data  <= '0;
`ifdef UART_DESER_PARITY_EN
            r_par_en    <= 1'b0;
            r_par_odd   <= 1'b0;
            r_cmp_perr  <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
            r_cmp_valid <= 1'b0;
            if (clear) begin
                // clear beats bit_en, so a last bit arriving with clear is lost.
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_shift <= '0;
            end else if (bit_en) begin
                case (r_state)
`ifdef UART_DESER_PARITY_EN
                    S_PAR: begin
                        r_state     <= S_IDLE;
                        r_cnt       <= '0;
                        r_shift     <= '0;
                        r_cmp_valid <= 1'b1;
                        r_cmp_data  <= r_shift;
                        // Even parity: data XOR parity must be 0. Odd parity: it must be 1.
                        r_cmp_perr  <= (^r_shift) ^ bit_in ^ r_par_odd;
                    end
`endif
                    default: begin
                        if (r_state == S_IDLE) begin
                            r_len     <= w_cfg_len;
                            r_msb     <= cfg_msb_first;
`ifdef UART_DESER_PARITY_EN
                            r_par_en  <= cfg_par_en;
                            r_par_odd <= cfg_par_odd;
`endif
                        end
                        if (w_last) begin
                            r_state     <= S_IDLE;
                            r_cnt       <= '0;
                            r_shift     <= '0;
                            r_cmp_valid <= 1'b1;
                            r_cmp_data  <= w_word;
`ifdef UART_DESER_PARITY_EN
                            r_cmp_perr  <= 1'b0;
                            // The later assignments override the completion above:
                            // hold the data and wait for the parity strobe.
                            if (w_par_en) begin
                                r_state     <= S_PAR;
                                r_cnt       <= w_len;
                                r_shift     <= w_word;
                                r_cmp_valid <= 1'b0;
                            end
`endif
                        end else begin
                            r_state <= S_SHIFT;
                            r_shift <= w_word;
                            r_cnt   <= w_cnt + LEN_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    // Output register. A word completed on the previous edge either loads
    // (output empty or being consumed now) or is dropped with an overrun pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_overrun   <= 1'b0;
`ifdef UART_DESER_PARITY_EN
            r_out_perr  <= 1'b0;
`endif
        end else begin
            r_overrun <= 1'b0;
            if (r_cmp_valid) begin
                if (!r_out_valid || out_ready) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_cmp_data;
`ifdef UART_DESER_PARITY_EN
                    r_out_perr  <= r_cmp_perr;
`endif
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign overrun   = r_overrun;
    assign busy      = (r_state != S_IDLE);
    assign bit_cnt   = r_cnt;
`ifdef UART_DESER_PARITY_EN
    assign out_par_err = r_out_perr;
`endif

endmodule
